// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down modulus counter family.
package counter_pkg;

  typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Clamp a parallel-load value into 0..modulus-1; out-of-range loads pin to the top.
  function automatic logic [31:0] sat_load(input logic [31:0] value,
                                           input logic [32:0] modulus);
    logic [32:0] lim;
    lim = modulus - 33'd1;
    if ({1'b0, value} > lim) return lim[31:0];
    return value;
  endfunction

endpackage

// File: rtl/tff_async.sv
// Single T flip-flop with asynchronous active-high reset.
module tff_async (
  input  logic Clock,
  input  logic Reset,
  input  logic T,
  output logic Q
);

  logic q_q, q_d;

  always_comb q_d = q_q ^ T;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulus counter with clear, saturating load, cascade
// carry (TerminalCount) and a registered Wrap pulse; state held in T flops.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             Enable,
  input  logic             Up,
  output logic [WIDTH-1:0] CounterValue,
  output logic             TerminalCount,
  output logic             Wrap
);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("mod_updown_counter: WIDTH %0d outside 2..32", WIDTH);
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [32:0]      MOD33   = 33'(MODULUS);

  logic [WIDTH-1:0] cnt_q, cnt_d, tog;
  logic             wrap_q, wrap_d;
  logic [31:0]      load_sat;
  dir_t             dir;

  assign dir = dir_t'(Up);

  always_comb load_sat = sat_load(32'(LoadValue), MOD33);

  // Bounds are compared explicitly so a non power-of-two modulus wraps correctly.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (Clear) begin
      cnt_d = '0;
    end else if (Load) begin
      cnt_d = load_sat[WIDTH-1:0];
    end else if (Enable) begin
      if (dir == UP) begin
        if (cnt_q == MAX_CNT) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d  = MAX_CNT;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  // Only bits that change get a toggle.
  assign tog = cnt_d ^ cnt_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_tff
    tff_async u_tff (
      .Clock (Clock),
      .Reset (Reset),
      .T     (tog[i]),
      .Q     (cnt_q[i])
    );
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end

  assign CounterValue  = cnt_q;
  assign Wrap          = wrap_q;
  assign TerminalCount = Enable & ((dir == UP) ? (cnt_q == MAX_CNT) : (cnt_q == '0));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: driver pushes hand-computed expectations, monitor checks them.
module tb_mod_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut4: WIDTH=4 MODULUS=10
  logic       rst4 = 1'b1, clr4 = 1'b0, ld4 = 1'b0, en4 = 1'b0, up4 = 1'b1;
  logic [3:0] lv4 = '0, cv4;
  logic       tc4, wr4;
  // dut8: WIDTH=8 MODULUS=256
  logic       rst8 = 1'b1, clr8 = 1'b0, ld8 = 1'b0, en8 = 1'b0, up8 = 1'b1;
  logic [7:0] lv8 = '0, cv8;
  logic       tc8, wr8;
  // cascade: two MODULUS=10 digits
  logic       rstc = 1'b1, enc = 1'b0;
  logic [3:0] cva, cvb;
  logic       tca, tcb, wra, wrb;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut4 (
    .Clock(clk), .Reset(rst4), .Clear(clr4), .Load(ld4), .LoadValue(lv4),
    .Enable(en4), .Up(up4), .CounterValue(cv4), .TerminalCount(tc4), .Wrap(wr4));

  mod_updown_counter #(.WIDTH(8), .MODULUS(256)) dut8 (
    .Clock(clk), .Reset(rst8), .Clear(clr8), .Load(ld8), .LoadValue(lv8),
    .Enable(en8), .Up(up8), .CounterValue(cv8), .TerminalCount(tc8), .Wrap(wr8));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .Clock(clk), .Reset(rstc), .Clear(1'b0), .Load(1'b0), .LoadValue(4'd0),
    .Enable(enc), .Up(1'b1), .CounterValue(cva), .TerminalCount(tca), .Wrap(wra));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
    .Clock(clk), .Reset(rstc), .Clear(1'b0), .Load(1'b0), .LoadValue(4'd0),
    .Enable(tca), .Up(1'b1), .CounterValue(cvb), .TerminalCount(tcb), .Wrap(wrb));

  typedef struct {
    int         sel;
    string      nm;
    logic [7:0] cv;
    logic       tc;
    logic       wr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // Inputs apply at the falling edge; expectations describe outputs seen
  // shortly after, i.e. state from all earlier rising edges plus these inputs.
  task automatic step(input int sel, input logic rst, clr, ld, input logic [7:0] lv,
                      input logic en, up, input logic [7:0] ecv, input logic etc, ewr,
                      input string nm);
    exp_t e;
    @(negedge clk);
    case (sel)
      0: begin rst4 = rst; clr4 = clr; ld4 = ld; lv4 = lv[3:0]; en4 = en; up4 = up; end
      1: begin rst8 = rst; clr8 = clr; ld8 = ld; lv8 = lv; en8 = en; up8 = up; end
      default: begin rstc = rst; enc = en; end
    endcase
    e.sel = sel; e.nm = nm; e.cv = ecv; e.tc = etc; e.wr = ewr;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t       e;
    logic [7:0] acv;
    logic       atc, awr;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          0:       begin acv = {4'd0, cv4}; atc = tc4; awr = wr4; end
          1:       begin acv = cv8;         atc = tc8; awr = wr8; end
          default: begin acv = {cvb, cva};  atc = tcb; awr = wrb; end
        endcase
        checks++;
        if (acv !== e.cv || atc !== e.tc || awr !== e.wr) begin
          errors++;
          $display("FAIL %s: got cv=%0d tc=%b wrap=%b, want cv=%0d tc=%b wrap=%b",
                   e.nm, acv, atc, awr, e.cv, e.tc, e.wr);
        end
      end
    end
  end

  initial begin
    // ---- dut4: reset, up wrap, down wrap ----
    step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, "rst_up_tc");
    step(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, "rst_dn_tc");
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 0, 0, 1, 1, 8'(i), (i == 9), 0, "up_count");
    step(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, "up_wrap_pulse");   // 9->0, now count down
    step(0, 0, 0, 0, 0, 1, 0, 9, 0, 1, "dn_wrap_pulse");   // 0->9 back-to-back wrap
    step(0, 0, 0, 1, 7, 0, 0, 8, 0, 0, "dn_step");
    // ---- load and priority ----
    step(0, 0, 0, 1, 13, 0, 0, 7, 0, 0, "load7");
    step(0, 0, 1, 1, 5, 0, 0, 9, 0, 0, "load_sat13");
    step(0, 0, 0, 1, 4, 1, 1, 0, 0, 0, "clear_beats_load");
    step(0, 0, 0, 0, 0, 1, 1, 4, 0, 0, "load_beats_en");
    step(0, 0, 0, 0, 0, 1, 1, 5, 0, 0, "count5");
    step(0, 0, 0, 0, 0, 1, 1, 6, 0, 0, "count6");
    // ---- async reset mid-count ----
    step(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, "async_rst");
    step(0, 1, 0, 1, 3, 1, 1, 0, 0, 0, "rst_hold_ld");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rst_release");
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, "after_rst");
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, "first_count");

    // ---- dut8: full-range binary ----
    step(1, 0, 0, 1, 250, 0, 1, 0, 0, 0, "b8_load250");
    for (int i = 250; i < 256; i++)
      step(1, 0, 0, 0, 0, 1, 1, 8'(i), (i == 255), 0, "b8_count");
    step(1, 0, 0, 1, 255, 0, 1, 0, 0, 1, "b8_wrap");
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, 0, 0, 1, 255, 0, 0, "b8_hold_tc0");
    step(1, 0, 0, 0, 0, 1, 1, 255, 1, 0, "b8_tc_en");
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, "b8_wrap2");

    // ---- cascade BCD 00..99 ----
    step(2, 1, 0, 0, 0, 0, 1, 0, 0, 0, "casc_rst");
    for (int k = 0; k < 100; k++)
      step(2, 0, 0, 0, 0, 1, 1, {4'(k / 10), 4'(k % 10)}, (k == 99), 0, "casc_count");
    step(2, 0, 0, 0, 0, 0, 1, 0, 0, 1, "casc_b_wrap");
    step(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, "casc_wrap_once");
    done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!done && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    if (!done || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: done=%0b pending=%0d, want done=1 pending=0", done, sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
